// File: rtl/register_file_pkg.sv
// Shared sizes and types for the WISC register file.
// Holds the data/index widths and the entry count derived from them.
package register_file_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/register_file_reg.sv
// One register-file entry: DATA_W flop, async active-low clear, write enable.
// Ports: i_clk, i_rst_n, i_we, i_d -> o_q (stored value).
import register_file_pkg::*;

module register_file_reg (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_we,
    input  reg_data_t i_d,
    output reg_data_t o_q
);

    reg_data_t r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// 16x16 register file: two combinational read ports, one clocked write port,
// R0 hard-wired to zero.
// Ports: clk, rst (async, active-low), SrcReg1/SrcReg2 -> SrcData1/SrcData2,
//        DstReg/DstData/WriteReg write port.
// Build option: define RF_BYPASS_EN to forward same-cycle write data to
// a read port addressing the register being written.
import register_file_pkg::*;

module register_file (
    input  logic      clk,
    input  logic      rst,
    input  reg_idx_t  SrcReg1,
    input  reg_idx_t  SrcReg2,
    input  reg_idx_t  DstReg,
    input  logic      WriteReg,
    input  reg_data_t DstData,
    output reg_data_t SrcData1,
    output reg_data_t SrcData2
);

    reg_data_t w_regs [NUM_REGS];
    reg_data_t w_rd1;
    reg_data_t w_rd2;

    // R0 is a constant, never stored.
    assign w_regs[0] = '0;

    genvar i;
    generate
        for (i = 1; i < NUM_REGS; i++) begin : g_reg
            logic w_we;

            // One-hot write select; index 0 never matches here.
            assign w_we = WriteReg && (DstReg == reg_idx_t'(i));

            register_file_reg u_reg (
                .i_clk   (clk),
                .i_rst_n (rst),
                .i_we    (w_we),
                .i_d     (DstData),
                .o_q     (w_regs[i])
            );
        end
    endgenerate

    assign w_rd1 = w_regs[SrcReg1];
    assign w_rd2 = w_regs[SrcReg2];

`ifdef RF_BYPASS_EN
    logic w_byp_en;

    // Forward only writes that will actually land.
    assign w_byp_en = WriteReg && rst && (DstReg != '0);

    assign SrcData1 = (w_byp_en && SrcReg1 == DstReg) ? DstData : w_rd1;
    assign SrcData2 = (w_byp_en && SrcReg2 == DstReg) ? DstData : w_rd2;
`else
    assign SrcData1 = w_rd1;
    assign SrcData2 = w_rd2;
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file (directed table + random + reset).
// Honours RF_BYPASS_EN when predicting same-cycle reads.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  SrcReg1 = '0;
    logic [3:0]  SrcReg2 = '0;
    logic [3:0]  DstReg = '0;
    logic        WriteReg = 1'b0;
    logic [15:0] DstData = '0;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;

    register_file dut (
        .clk      (clk),
        .rst      (rst),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .DstReg   (DstReg),
        .WriteReg (WriteReg),
        .DstData  (DstData),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  dst;
        logic [15:0] data;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    typedef struct {
        logic [15:0] e1;
        logic [15:0] e2;
    } exp_t;

    logic [15:0] mdl [16];
    exp_t        sbq [$];
    int          n_run = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] pre_rd(input vec_t v, input logic [3:0] s);
        logic [15:0] r;
        r = (s == 4'd0) ? 16'h0000 : mdl[s];
`ifdef RF_BYPASS_EN
        if (v.we && v.dst != 4'd0 && s == v.dst)
            r = v.data;
`endif
        return r;
    endfunction

    function automatic vec_t predict(input vec_t v);
        vec_t        o;
        logic [15:0] nm [16];
        o = v;
        nm = mdl;
        if (v.we && v.dst != 4'd0)
            nm[v.dst] = v.data;
        o.e1 = (v.s1 == 4'd0) ? 16'h0000 : nm[v.s1];
        o.e2 = (v.s2 == 4'd0) ? 16'h0000 : nm[v.s2];
        return o;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        @(negedge clk);
        WriteReg = v.we;
        DstReg   = v.dst;
        DstData  = v.data;
        SrcReg1  = v.s1;
        SrcReg2  = v.s2;
        #1;
        chk({nm, "_pre1"}, SrcData1, pre_rd(v, v.s1));
        chk({nm, "_pre2"}, SrcData2, pre_rd(v, v.s2));
        e.e1 = v.e1;
        e.e2 = v.e2;
        sbq.push_back(e);
        @(posedge clk);
        if (v.we && v.dst != 4'd0)
            mdl[v.dst] = v.data;
        #1;
        if (sbq.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL %s_sb: got empty expected entry", nm);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_post1"}, SrcData1, e.e1);
            chk({nm, "_post2"}, SrcData2, e.e2);
        end
    endtask

    vec_t tbl [8];
    vec_t v;

    initial begin
        tbl[0] = '{1'b1, 4'd1,  16'h0001, 4'd0,  4'd1,  16'h0000, 16'h0001};
        tbl[1] = '{1'b1, 4'd2,  16'h000F, 4'd0,  4'd1,  16'h0000, 16'h0001};
        tbl[2] = '{1'b0, 4'd2,  16'h5555, 4'd2,  4'd1,  16'h000F, 16'h0001};
        tbl[3] = '{1'b1, 4'd0,  16'hFFFF, 4'd0,  4'd0,  16'h0000, 16'h0000};
        tbl[4] = '{1'b1, 4'd3,  16'hA5A5, 4'd3,  4'd3,  16'hA5A5, 16'hA5A5};
        tbl[5] = '{1'b1, 4'd1,  16'hBEEF, 4'd2,  4'd1,  16'h000F, 16'hBEEF};
        tbl[6] = '{1'b0, 4'd3,  16'h1111, 4'd3,  4'd15, 16'hA5A5, 16'h0000};
        tbl[7] = '{1'b1, 4'd15, 16'hCAFE, 4'd15, 4'd0,  16'hCAFE, 16'h0000};

        for (int k = 0; k < 16; k++)
            mdl[k] = 16'h0000;

        // Reset state: every entry reads zero while and after reset.
        rst = 1'b0;
        SrcReg1 = 4'd0;
        SrcReg2 = 4'd1;
        #12;
        chk("rst_s1", SrcData1, 16'h0000);
        chk("rst_s2", SrcData2, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            SrcReg1 = 4'(k);
            SrcReg2 = 4'(15 - k);
            #1;
            chk($sformatf("rst_all_%0d", k), SrcData1, 16'h0000);
            chk($sformatf("rst_allb_%0d", k), SrcData2, 16'h0000);
        end

        for (int k = 0; k < 8; k++)
            apply(tbl[k], $sformatf("vec%0d", k));

        for (int k = 0; k < 60; k++) begin
            v.we   = 1'($urandom_range(0, 1));
            v.dst  = 4'($urandom_range(0, 15));
            v.data = 16'($urandom);
            v.s1   = ($urandom_range(0, 3) == 0) ? v.dst : 4'($urandom_range(0, 15));
            v.s2   = 4'($urandom_range(0, 15));
            v = predict(v);
            apply(v, $sformatf("rnd%0d", k));
        end

        // R5 write, then async reset mid-cycle with no clock edge.
        v = '{1'b1, 4'd5, 16'h1234, 4'd5, 4'd5, 16'h1234, 16'h1234};
        apply(v, "r5wr");
        @(negedge clk);
        WriteReg = 1'b0;
        SrcReg1  = 4'd5;
        SrcReg2  = 4'd5;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_r5", SrcData1, 16'h0000);
        for (int k = 0; k < 16; k++)
            mdl[k] = 16'h0000;
        WriteReg = 1'b1;
        DstReg   = 4'd5;
        DstData  = 16'h7777;
        #1;
        chk("rst_nobyp", SrcData2, 16'h0000);
        @(posedge clk);
        #1;
        chk("rst_wr_blk1", SrcData1, 16'h0000);
        chk("rst_wr_blk2", SrcData2, 16'h0000);
        @(negedge clk);
        WriteReg = 1'b0;
        rst = 1'b1;
        #1;
        chk("rel_r5", SrcData1, 16'h0000);

        v = '{1'b1, 4'd5, 16'h4321, 4'd5, 4'd1, 16'h4321, 16'h0000};
        apply(v, "post_rel");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
